// File: rtl/present_inv_key_schedule_if.sv
// Handshake bundle between the decrypt datapath and the inverse PRESENT-80 key schedule.
interface present_inv_key_schedule_if;
  logic        start;
  logic [79:0] key;
  logic        busy;
  logic        rk_valid;
  logic        rk_next;
  logic [63:0] roundkey;
  logic [5:0]  rk_index;
  logic        done;

  modport master (
    output start, key, rk_next,
    input  busy, rk_valid, roundkey, rk_index, done
  );

  modport slave (
    input  start, key, rk_next,
    output busy, rk_valid, roundkey, rk_index, done
  );
endinterface

// File: rtl/present_inv_key_schedule.sv
// Memoryless PRESENT-80 round-key source, keys emitted K32..K1; first key 32 edges after start.
// One key per rk_next handshake; outputs hold while rk_next is low, start ignored until DONE.
module present_inv_key_schedule #(
  parameter int NUM_ROUNDS = 31
) (
  input logic                      clk,
  input logic                      rst,
  present_inv_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY, DONE} state_t;

  state_t      state, state_nxt;
  logic [79:0] k, k_nxt, k_fwd, k_inv, u;
  logic [5:0]  rcnt, rcnt_nxt;
  logic [5:0]  idx, idx_nxt;
  logic [4:0]  r;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // Forward step uses rcnt; inverse step undoes the update that produced round rk_index.
  always_comb begin
    k_fwd          = {k[18:0], k[79:19]};
    k_fwd[79:76]   = sbox(k_fwd[79:76]);
    k_fwd[19:15]   = k_fwd[19:15] ^ rcnt[4:0];
    r              = idx[4:0] - 5'd1;
    u              = k;
    u[19:15]       = u[19:15] ^ r;
    u[79:76]       = sbox_inv(u[79:76]);
    k_inv          = {u[60:0], u[79:61]};
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    rcnt_nxt  = rcnt;
    idx_nxt   = idx;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          k_nxt     = bus.key;
          rcnt_nxt  = 6'd1;
          idx_nxt   = 6'd0;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        k_nxt    = k_fwd;
        rcnt_nxt = rcnt + 6'd1;
        if (rcnt == 6'(NUM_ROUNDS)) begin
          idx_nxt   = 6'(NUM_ROUNDS + 1);
          state_nxt = READY;
        end
      end
      READY: begin
        if (bus.rk_next) begin
          if (idx > 6'd1) begin
            k_nxt   = k_inv;
            idx_nxt = idx - 6'd1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      rcnt  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      rcnt  <= rcnt_nxt;
      idx   <= idx_nxt;
    end
  end

  assign bus.busy     = (state == EXPAND);
  assign bus.rk_valid = (state == READY);
  assign bus.done     = (state == DONE);
  assign bus.roundkey = k[79:16];
  assign bus.rk_index = idx;

endmodule

// File: tb/tb_present_inv_key_schedule.sv
// Scoreboarded bench: forward-model round keys queued at start, compared at each handshake.
module tb_present_inv_key_schedule;

  logic clk = 1'b0;
  logic rst;

  present_inv_key_schedule_if bus ();

  present_inv_key_schedule #(.NUM_ROUNDS(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [63:0] rk;
  } exp_t;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [79:0] fwd(input logic [79:0] k, input int rnd);
    logic [79:0] t;
    logic [4:0]  rc;
    rc        = rnd[4:0];
    t         = {k[18:0], k[79:19]};
    t[79:76]  = SBOX[t[79:76]];
    t[19:15]  = t[19:15] ^ rc;
    return t;
  endfunction

  task automatic do_start(input logic [79:0] key);
    logic [79:0] k;
    sb.delete();
    k = key;
    for (int i = 1; i <= 32; i++) begin
      sb.push_front({6'(i), k[79:16]});
      if (i < 32) k = fwd(k, i);
    end
    bus.key   = key;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    int busy_cnt;
    n        = 1;
    busy_cnt = 0;
    check("done_clear", 80'(bus.done), 80'(0));
    while (!bus.rk_valid && n < 100) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 80'(n), 80'(32));
    check("busy_cycles", 80'(busy_cnt), 80'(31));
  endtask

  task automatic drain(input bit rnd, input bit start_noise, input int stop_idx,
                       input logic [79:0] key);
    int   budget;
    bit   stop;
    bit   nxt;
    exp_t e;
    budget = 0;
    stop   = 1'b0;
    while (sb.size() > 0 && budget < 400 && !stop) begin
      e = sb[0];
      if (int'(e.idx) == stop_idx) begin
        stop = 1'b1;
      end else begin
        check("rk_valid", 80'(bus.rk_valid), 80'(1));
        check("rk_index", 80'(bus.rk_index), 80'(e.idx));
        check("roundkey", 80'(bus.roundkey), 80'(e.rk));
        if (key == 80'd0 && e.idx == 6'd2)
          check("k0_idx2", 80'(bus.roundkey), 80'(64'hC000000000000000));
        nxt = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
        if (nxt) begin
          bus.rk_next = 1'b1;
          void'(sb.pop_front());
        end else if (start_noise && $urandom_range(0, 3) == 0) begin
          bus.start = 1'b1;
          bus.key   = 80'({$urandom, $urandom, $urandom});
        end
        @(posedge clk); #1;
        bus.rk_next = 1'b0;
        bus.start   = 1'b0;
        budget++;
      end
    end
    if (!stop) begin
      if (sb.size() > 0) begin
        check("drain_timeout", 80'(sb.size()), 80'(0));
      end else begin
        check("done", 80'(bus.done), 80'(1));
        check("valid_after", 80'(bus.rk_valid), 80'(0));
        check("rk_final", 80'(bus.roundkey), 80'(key[79:16]));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  80'(bus.busy),     80'(0));
    check({tag, "_valid"}, 80'(bus.rk_valid), 80'(0));
    check({tag, "_done"},  80'(bus.done),     80'(0));
    check({tag, "_idx"},   80'(bus.rk_index), 80'(0));
    check({tag, "_rk"},    80'(bus.roundkey), 80'(0));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [79:0] k;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.key     = '0;
    bus.rk_next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // All-zero key: hold with no rk_next, then drain continuously.
    do_start(80'd0);
    wait_ready();
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_idx", 80'(bus.rk_index), 80'(32));
      check("hold_rk", 80'(bus.roundkey), 80'(sb[0].rk));
    end
    drain(1'b0, 1'b0, 0, 80'd0);

    // All-ones key from DONE, random rk_next, stray start pulses in READY.
    k = '1;
    do_start(k);
    wait_ready();
    drain(1'b1, 1'b1, 0, k);

    // Reset in the middle of expansion.
    do_start(80'h0123456789ABCDEF0123);
    repeat (9) @(posedge clk);
    #1;
    pulse_rst();
    check_zero("rst_expand");
    @(posedge clk); #1;
    check("idle_busy", 80'(bus.busy), 80'(0));

    // Reset in READY at rk_index 17.
    do_start(80'h0123456789ABCDEF0123);
    wait_ready();
    drain(1'b1, 1'b0, 17, 80'h0123456789ABCDEF0123);
    check("pre_rst_idx", 80'(bus.rk_index), 80'(17));
    pulse_rst();
    check_zero("rst_ready");

    do_start(80'h0123456789ABCDEF0123);
    wait_ready();
    drain(1'b0, 1'b0, 0, 80'h0123456789ABCDEF0123);

    for (int i = 0; i < 200; i++) begin
      k = 80'({$urandom, $urandom, $urandom});
      do_start(k);
      wait_ready();
      drain(i[0], 1'b0, 0, k);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
